mem_bus_target: RTL and testbench

//  Parametrised memory target on the req/gnt/start/rdy CPU-memory bus.

---
 rtl/mem_bus_target.sv | 196 +++++++++++++++++++
 tb/tb_mem_bus_target.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_target.sv
// mem_bus_target: memory target on the req/gnt/start/rdy CPU-memory bus.
//
// A master raises req and gets gnt. While granted it presents a command
// with start. The command waits WAIT_STATES extra cycles, then runs. It
// completes with a one-cycle rdy pulse that carries rdata and err.
//
// Parameters:
//   DW          data width
//   AW          address width
//   DEPTH       number of implemented words (1..2**AW); addr >= DEPTH is an error
//   WAIT_STATES extra cycles between start and rdy (0..15)
//   CNT_W       width of the statistics counters
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   req     master requests the bus
//   start   command valid; sampled only while granted and in GRANT
//   addr    command address
//   mode    00 read, 01 write, 10 clear (write zero), 11 illegal
//   wdata   write data
//   gnt     bus granted
//   rdy     one-cycle command completion
//   rdata   read data, valid only with rdy (zero otherwise)
//   err     command failed, valid only with rdy
//   rd_cnt  completed error-free reads, saturating
//   wr_cnt  completed error-free writes/clears, saturating
//
// Build option:
//   MEM_BUS_STATS_EN  When defined, the design builds the rd_cnt/wr_cnt
//                     counters. When undefined, both outputs are tied to
//                     zero and no counter flops exist.
//
// Contents of the storage array are not affected by reset.

module mem_bus_target #(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             start,
  input  logic [AW-1:0]    addr,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    wdata,
  output logic             gnt,
  output logic             rdy,
  output logic [DW-1:0]    rdata,
  output logic             err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ModeRead  = 2'b00;
  localparam logic [1:0] ModeWrite = 2'b01;
  localparam logic [1:0] ModeClear = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StAccess,
    StDone
  } state_e;

  state_e          state_q;
  logic [3:0]      wcnt_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      mode_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   res_data_q;
  logic            res_err_q;

  logic [DW-1:0]   mem [DEPTH];

  logic            in_range;
  logic            cmd_err;
  logic            exec;
  logic            mem_we;
  logic [IW-1:0]   mem_idx;
  logic [DW-1:0]   mem_rdata;

  always_comb begin
    in_range  = (32'(addr_q) < DEPTH);
    cmd_err   = (mode_q == 2'b11) || !in_range;
    exec      = (state_q == StAccess) && (wcnt_q == 4'd0);
    mem_idx   = addr_q[IW-1:0];
    mem_rdata = in_range ? mem[mem_idx] : '0;
    mem_we    = exec && !cmd_err && ((mode_q == ModeWrite) || (mode_q == ModeClear));
  end

  // Storage array. It has no reset, so it can map onto RAM. The write is
  // gated by state_q. An asynchronous reset therefore drops any pending
  // write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= (mode_q == ModeWrite) ? wdata_q : '0;
    end
  end

  // Control FSM with registered outputs. The command executes on the edge
  // that enters DONE. The storage array updates and the result is captured
  // on that same edge. DONE then drives rdy/rdata/err for the following
  // cycle. That timing puts rdy WAIT_STATES+2 cycles after the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt        <= 1'b0;
      rdy        <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      wcnt_q     <= 4'd0;
      addr_q     <= '0;
      mode_q     <= ModeRead;
      wdata_q    <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      rdy   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            state_q <= StGrant;
            gnt     <= 1'b1;
          end
        end
        StGrant: begin
          if (start) begin
            addr_q  <= addr;
            mode_q  <= mode;
            wdata_q <= wdata;
            wcnt_q  <= 4'(WAIT_STATES);
            state_q <= StAccess;
          end else if (!req) begin
            state_q <= StIdle;
            gnt     <= 1'b0;
          end
        end
        StAccess: begin
          if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end else begin
            res_data_q <= (!cmd_err && (mode_q == ModeRead)) ? mem_rdata : '0;
            res_err_q  <= cmd_err;
            state_q    <= StDone;
          end
        end
        StDone: begin
          rdy   <= 1'b1;
          rdata <= res_data_q;
          err   <= res_err_q;
          if (req) begin
            state_q <= StGrant;
          end else begin
            state_q <= StIdle;
            gnt     <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt     <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_BUS_STATS_EN
  // Counters advance on the same edge that raises rdy. mode_q still holds
  // the completing command during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if ((state_q == StDone) && !res_err_q) begin
      if (mode_q == ModeRead) begin
        if (rd_cnt != {CNT_W{1'b1}}) begin
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end else if (wr_cnt != {CNT_W{1'b1}}) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_bus_target.sv
// Self-checking bench for mem_bus_target. It uses two instances:
//   dut_a: WAIT_STATES=0, DEPTH=200, CNT_W=2 (function, range, saturation)
//   dut_b: WAIT_STATES=3, DEPTH=256         (latency, reset mid-access)
module tb_mem_bus_target;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic [1:0] mode;
  logic [7:0] wdata;

  logic       req_a, start_a, gnt_a, rdy_a, err_a;
  logic [7:0] rdata_a;
  logic [1:0] rd_cnt_a, wr_cnt_a;

  logic        req_b, start_b, gnt_b, rdy_b, err_b;
  logic [7:0]  rdata_b;
  logic [15:0] rd_cnt_b, wr_cnt_b;

  int n_checks;
  int n_errors;

`ifdef MEM_BUS_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  mem_bus_target #(
    .DW(8), .AW(8), .DEPTH(200), .WAIT_STATES(0), .CNT_W(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .start(start_a), .addr(addr),
    .mode(mode), .wdata(wdata), .gnt(gnt_a), .rdy(rdy_a), .rdata(rdata_a),
    .err(err_a), .rd_cnt(rd_cnt_a), .wr_cnt(wr_cnt_a)
  );

  mem_bus_target #(
    .DW(8), .AW(8), .DEPTH(256), .WAIT_STATES(3), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .start(start_b), .addr(addr),
    .mode(mode), .wdata(wdata), .gnt(gnt_b), .rdy(rdy_b), .rdata(rdata_b),
    .err(err_b), .rd_cnt(rd_cnt_b), .wr_cnt(wr_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic sel_gnt(input bit sel);
    return sel ? gnt_b : gnt_a;
  endfunction

  function automatic logic sel_rdy(input bit sel);
    return sel ? rdy_b : rdy_a;
  endfunction

  // Issue one command on instance sel (0=a, 1=b). The task is called at a
  // negedge. It returns at the negedge where rdy is seen. lat counts cycles
  // from the start sample edge; 99 means no rdy was seen.
  task automatic do_cmd(input bit sel, input logic [1:0] m, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] rd, output logic e,
                        output int lat, output logic [15:0] rc, output logic [15:0] wc);
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sel_gnt(sel)) break;
      @(negedge clk);
    end
    check("gnt_wait", 32'(sel_gnt(sel)), 32'd1);
    mode  = m;
    addr  = a;
    wdata = d;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 99;
    rd  = '0;
    e   = 1'b0;
    rc  = '0;
    wc  = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (sel_rdy(sel)) begin
        lat = c;
        rd  = sel ? rdata_b : rdata_a;
        e   = sel ? err_b : err_a;
        rc  = sel ? rd_cnt_b : 16'(rd_cnt_a);
        wc  = sel ? wr_cnt_b : 16'(wr_cnt_a);
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] m;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic [1:0] exp_rd;   // counter values in the rdy cycle with stats enabled
    logic [1:0] exp_wr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0]  rd;
    logic        e;
    int          lat;
    int          rdy_seen;
    logic [15:0] rc;
    logic [15:0] wc;

    n_checks = 0;
    n_errors = 0;

    //          mode   addr   wdata  rdata  err   rd    wr
    vecs[0]  = '{2'b01, 8'h10, 8'hA5, 8'h00, 1'b0, 2'd0, 2'd1};
    vecs[1]  = '{2'b00, 8'h10, 8'h00, 8'hA5, 1'b0, 2'd1, 2'd1};
    vecs[2]  = '{2'b01, 8'h11, 8'h3C, 8'h00, 1'b0, 2'd1, 2'd2};
    vecs[3]  = '{2'b10, 8'h10, 8'hEE, 8'h00, 1'b0, 2'd1, 2'd3};
    vecs[4]  = '{2'b00, 8'h10, 8'h00, 8'h00, 1'b0, 2'd2, 2'd3};
    vecs[5]  = '{2'b11, 8'h11, 8'hFF, 8'h00, 1'b1, 2'd2, 2'd3};
    vecs[6]  = '{2'b00, 8'h11, 8'h00, 8'h3C, 1'b0, 2'd3, 2'd3};
    vecs[7]  = '{2'b00, 8'hC8, 8'h00, 8'h00, 1'b1, 2'd3, 2'd3};
    vecs[8]  = '{2'b01, 8'hC7, 8'h77, 8'h00, 1'b0, 2'd3, 2'd3};
    vecs[9]  = '{2'b00, 8'hC7, 8'h00, 8'h77, 1'b0, 2'd3, 2'd3};
    vecs[10] = '{2'b01, 8'hC8, 8'h55, 8'h00, 1'b1, 2'd3, 2'd3};
    vecs[11] = '{2'b00, 8'hFF, 8'h00, 8'h00, 1'b1, 2'd3, 2'd3};

    rst_n = 1'b0;
    req_a = 1'b0; start_a = 1'b0;
    req_b = 1'b0; start_b = 1'b0;
    addr = '0; mode = '0; wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_rdy_a", 32'(rdy_a), 32'd0);
    check("rst_rdata_a", 32'(rdata_a), 32'd0);
    check("rst_cnt_a", 32'({rd_cnt_a, wr_cnt_a}), 32'd0);
    rst_n = 1'b1;

    // Instance b: known value, then a write abandoned by reset mid-ACCESS.
    do_cmd(1'b1, 2'b01, 8'h10, 8'h3C, rd, e, lat, rc, wc);
    check("b_wr_lat", 32'(lat), 32'd5);
    check("b_wr_err", 32'(e), 32'd0);
    @(negedge clk);
    mode = 2'b01; addr = 8'h10; wdata = 8'h77; start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    repeat (2) @(negedge clk);
    check("b_gnt_in_access", 32'(gnt_b), 32'd1);
    rst_n = 1'b0;
    #1;
    check("b_rst_gnt", 32'(gnt_b), 32'd0);
    check("b_rst_rdy", 32'(rdy_b), 32'd0);
    check("b_rst_err", 32'(err_b), 32'd0);
    check("b_rst_rdata", 32'(rdata_b), 32'd0);
    check("b_rst_cnt", 32'(rd_cnt_b) + 32'(wr_cnt_b), 32'd0);
    req_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_cmd(1'b1, 2'b00, 8'h10, 8'h00, rd, e, lat, rc, wc);
    check("b_abandoned_write", 32'(rd), 32'h3C);

    // Instance b: wait-state latency and single-cycle rdy.
    @(negedge clk);
    do_cmd(1'b1, 2'b01, 8'h20, 8'h5A, rd, e, lat, rc, wc);
    @(negedge clk);
    do_cmd(1'b1, 2'b00, 8'h20, 8'h00, rd, e, lat, rc, wc);
    check("b_rd_lat", 32'(lat), 32'd5);
    check("b_rd_data", 32'(rd), 32'h5A);
    check("b_rd_err", 32'(e), 32'd0);
    @(negedge clk);
    check("b_rdy_pulse", 32'(rdy_b), 32'd0);
    req_b = 1'b0;

    // Instance a: table of commands.
    for (int i = 0; i < 12; i++) begin
      do_cmd(1'b0, vecs[i].m, vecs[i].a, vecs[i].d, rd, e, lat, rc, wc);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_rd_cnt", i), 32'(rc), Stats ? 32'(vecs[i].exp_rd) : 32'd0);
      check($sformatf("v%0d_wr_cnt", i), 32'(wc), Stats ? 32'(vecs[i].exp_wr) : 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_rdy_pulse", i), 32'(rdy_a), 32'd0);
    end

    // Back-to-back: start sampled right after the rdy cycle sees new data.
    do_cmd(1'b0, 2'b01, 8'h12, 8'h99, rd, e, lat, rc, wc);
    do_cmd(1'b0, 2'b00, 8'h12, 8'h00, rd, e, lat, rc, wc);
    check("b2b_lat", 32'(lat), 32'd2);
    check("b2b_rdata", 32'(rd), 32'h99);

    // start outside GRANT is ignored.
    req_a = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_gnt", 32'(gnt_a), 32'd0);
    mode = 2'b01; addr = 8'h11; wdata = 8'hEE; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    rdy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rdy_a) rdy_seen++;
    end
    check("ignored_start_rdy", 32'(rdy_seen), 32'd0);
    check("ignored_start_gnt", 32'(gnt_a), 32'd0);
    req_a = 1'b1;
    @(negedge clk);
    check("grant_latency", 32'(gnt_a), 32'd1);
    do_cmd(1'b0, 2'b00, 8'h11, 8'h00, rd, e, lat, rc, wc);
    check("ignored_start_mem", 32'(rd), 32'h3C);
    req_a = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
